// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: parity encodings, the
// serializer state encoding and the baud divisor helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles per bit; integer truncation is intended.
  function automatic int divisor(input int clock_freq, input int baud);
    return clock_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART serializer. The ready flag is
// registered from the next-cycle count; it does not anticipate a future pop.
module uart_tx_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic [Width-1:0]             pop_data,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         ready
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ready_q, ready_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign ready    = ready_q;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a signal unassigned and no latch appears.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d < CntW'(Depth));
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  // NOTE: the storage array has no reset; count and pointers alone decide
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: buffers words from a ready/valid port and shifts each one
// out LSB-first as start / data / optional parity / stop bits on SOut.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int ClockFreq = 200000000,
  parameter int Baud      = 9600,
  parameter int Width     = 8,
  parameter int Parity    = 0,
  parameter int StopBits  = 1,
  parameter int FIFODepth = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [Width-1:0] DataIn,
  input  logic             DataInValid,
  output logic             DataInReady,
  output logic             SOut,
  output logic             Busy
);

  localparam int Divisor = divisor(ClockFreq, Baud);
  localparam int BaudW   = $clog2(Divisor);
  localparam int BitW    = $clog2(Width + 1);
  localparam int CntW    = $clog2(FIFODepth + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(Divisor - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(Width - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(StopBits - 1);

  if (Divisor < 2) begin : g_chk_divisor
    $error("uart_tx_serializer: ClockFreq/Baud must be at least 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_chk_stop
    $error("uart_tx_serializer: StopBits must be 1 or 2");
  end
  if (FIFODepth < 2 || (FIFODepth & (FIFODepth - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_serializer: FIFODepth must be a power of 2, at least 2");
  end

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [Width-1:0] shift_q, shift_d;
  logic             par_bit_q, par_bit_d;
  logic             sout_q, sout_d;

  logic             fifo_push, fifo_pop;
  logic [Width-1:0] fifo_head;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_full, fifo_empty, fifo_ready;
  logic             bit_done, load_next;

  assign fifo_push = DataInValid && DataInReady && !fifo_full;

  uart_tx_fifo #(
    .Width (Width),
    .Depth (FIFODepth)
  ) u_fifo (
    .clk       (Clock),
    .rst_n     (Reset),
    .push      (fifo_push),
    .push_data (DataIn),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ready     (fifo_ready)
  );

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    sout_d     = sout_q;
    fifo_pop   = 1'b0;
    load_next  = 1'b0;
    bit_done   = (baud_cnt_q == BaudLast);

    // The baud counter runs in every active state and restarts at each bit boundary.
    if (state_q != ST_IDLE) begin
      baud_cnt_d = bit_done ? '0 : baud_cnt_q + BaudW'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        load_next = !fifo_empty;
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          sout_d    = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            if (Parity != PARITY_NONE) begin
              state_d = ST_PARITY;
              sout_d  = par_bit_q;
            end else begin
              state_d = ST_STOP;
              sout_d  = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            sout_d    = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d   = ST_STOP;
          sout_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_cnt_q == StopLast) begin
            // A waiting word starts on this same edge, so frames abut.
            if (!fifo_empty) begin
              load_next = 1'b1;
            end else begin
              state_d   = ST_IDLE;
              bit_cnt_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sout_d  = 1'b1;
      end
    endcase

    if (load_next) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_head;
      par_bit_d  = (Parity == PARITY_ODD) ? ~(^fifo_head) : ^fifo_head;
      sout_d     = 1'b0;
      state_d    = ST_START;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      sout_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      sout_q     <= sout_d;
    end
  end

  assign DataInReady = fifo_ready;
  assign SOut        = sout_q;
  assign Busy        = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: four instances (8N1, 8E1, 8O1, 8N2)
// at Divisor=10, checked cycle by cycle against hand-built frame bit vectors.
module tb_uart_tx_serializer;

  localparam int DIV = 10;

  logic       clk;
  logic       rst_n;
  logic [7:0] din [4];
  logic [3:0] vld;
  wire  [3:0] rdy;
  wire  [3:0] sout;
  wire  [3:0] busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] chars [6];

  uart_tx_serializer #(.ClockFreq(1000), .Baud(100), .Width(8), .Parity(0),
                       .StopBits(1), .FIFODepth(4)) dut_8n1 (
    .Clock(clk), .Reset(rst_n), .DataIn(din[0]), .DataInValid(vld[0]),
    .DataInReady(rdy[0]), .SOut(sout[0]), .Busy(busy[0]));

  uart_tx_serializer #(.ClockFreq(1000), .Baud(100), .Width(8), .Parity(2),
                       .StopBits(1), .FIFODepth(4)) dut_8e1 (
    .Clock(clk), .Reset(rst_n), .DataIn(din[1]), .DataInValid(vld[1]),
    .DataInReady(rdy[1]), .SOut(sout[1]), .Busy(busy[1]));

  uart_tx_serializer #(.ClockFreq(1000), .Baud(100), .Width(8), .Parity(1),
                       .StopBits(1), .FIFODepth(4)) dut_8o1 (
    .Clock(clk), .Reset(rst_n), .DataIn(din[2]), .DataInValid(vld[2]),
    .DataInReady(rdy[2]), .SOut(sout[2]), .Busy(busy[2]));

  uart_tx_serializer #(.ClockFreq(1000), .Baud(100), .Width(8), .Parity(0),
                       .StopBits(2), .FIFODepth(4)) dut_8n2 (
    .Clock(clk), .Reset(rst_n), .DataIn(din[3]), .DataInValid(vld[3]),
    .DataInReady(rdy[3]), .SOut(sout[3]), .Busy(busy[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, run %0d failed %0d",
             tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  // bits[i] is the line level during bit period i; each period is sampled DIV times.
  task automatic check_frame(input int sel, input logic [15:0] bits,
                             input int nbits, input string name);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        tests_run++;
        if (sout[sel] !== bits[b]) begin
          tests_failed++;
          $display("FAIL %s bit%0d cyc%0d: SOut=%b expected %b",
                   name, b, c, sout[sel], bits[b]);
        end
      end
    end
  endtask

  task automatic send_one(input int sel, input logic [7:0] data,
                          input logic [15:0] bits, input int nbits,
                          input string name);
    @(negedge clk);
    tests_run++;
    if (rdy[sel] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s ready: DataInReady=%b expected 1", name, rdy[sel]);
    end
    din[sel] = data;
    vld[sel] = 1'b1;
    @(negedge clk);
    vld[sel] = 1'b0;
    tests_run++;
    if (sout[sel] !== 1'b1 || busy[sel] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s accept: SOut=%b Busy=%b expected SOut=1 Busy=1",
               name, sout[sel], busy[sel]);
    end
    check_frame(sel, bits, nbits, name);
    @(negedge clk);
    tests_run++;
    if (busy[sel] !== 1'b0 || sout[sel] !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s end: Busy=%b SOut=%b expected Busy=0 SOut=1",
               name, busy[sel], sout[sel]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    vld   = '0;
    for (int i = 0; i < 4; i++) din[i] = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (sout[i] !== 1'b1 || rdy[i] !== 1'b0 || busy[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold dut%0d: SOut=%b Ready=%b Busy=%b expected 1,0,0",
                 i, sout[i], rdy[i], busy[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rdy !== 4'hF || busy !== 4'h0 || sout !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_release: Ready=%b Busy=%b SOut=%b expected 1111,0000,1111",
               rdy, busy, sout);
    end
  endtask

  task automatic test_8n1();
    send_one(0, 8'h55, 16'h02AA, 10, "8n1_0x55");
    send_one(0, 8'h00, 16'h0200, 10, "8n1_0x00");
    send_one(0, 8'hFF, 16'h03FE, 10, "8n1_0xFF");
  endtask

  task automatic test_parity();
    send_one(1, 8'h07, 16'h060E, 11, "8e1_0x07");
    send_one(2, 8'h07, 16'h040E, 11, "8o1_0x07");
  endtask

  task automatic test_back_to_back();
    int waited;
    chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tests_run++;
          if (rdy[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_push%0d: DataInReady=%b expected 1", i, rdy[0]);
          end
          din[0] = chars[i];
          vld[0] = 1'b1;
          @(negedge clk);
        end
        // FIFO now holds four words; the sixth stays offered until space frees up.
        din[0] = chars[5];
        waited = 0;
        while (rdy[0] !== 1'b1 && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        tests_run++;
        if (waited !== 97) begin
          tests_failed++;
          $display("FAIL b2b_full_window: ready returned after %0d cycles expected 97",
                   waited);
        end
        @(negedge clk);
        vld[0] = 1'b0;
      end
      begin
        @(negedge clk);
        tests_run++;
        if (sout[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_latency: SOut=%b expected 1", sout[0]);
        end
        for (int f = 0; f < 6; f++) begin
          check_frame(0, {6'b0, 1'b1, chars[f], 1'b0}, 10, $sformatf("b2b_frame%0d", f));
        end
        @(negedge clk);
        tests_run++;
        if (busy[0] !== 1'b0 || sout[0] !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_end: Busy=%b SOut=%b expected Busy=0 SOut=1",
                   busy[0], sout[0]);
        end
      end
    join
  endtask

  task automatic test_stop2();
    @(negedge clk);
    fork
      begin
        din[3] = 8'h41;
        vld[3] = 1'b1;
        @(negedge clk);
        din[3] = 8'h42;
        @(negedge clk);
        vld[3] = 1'b0;
      end
      begin
        @(negedge clk);
        check_frame(3, {5'b0, 2'b11, 8'h41, 1'b0}, 11, "8n2_frame0");
        check_frame(3, {5'b0, 2'b11, 8'h42, 1'b0}, 11, "8n2_frame1");
        @(negedge clk);
        tests_run++;
        if (busy[3] !== 1'b0 || sout[3] !== 1'b1) begin
          tests_failed++;
          $display("FAIL 8n2_end: Busy=%b SOut=%b expected Busy=0 SOut=1",
                   busy[3], sout[3]);
        end
      end
    join
  endtask

  task automatic test_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests_run++;
      if (sout !== 4'hF || busy !== 4'h0) begin
        tests_failed++;
        $display("FAIL idle cyc%0d: SOut=%b Busy=%b expected 1111,0000", i, sout, busy);
      end
    end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    din[0] = 8'h00;
    vld[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h41;
    @(negedge clk);
    din[0] = 8'h42;
    @(negedge clk);
    vld[0] = 1'b0;
    // Now one cycle into the 0x00 frame; advance to cycle 35 (data bit 2, low).
    repeat (34) @(negedge clk);
    tests_run++;
    if (sout[0] !== 1'b0 || busy[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL midframe_pre: SOut=%b Busy=%b expected 0,1", sout[0], busy[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (sout[0] !== 1'b1 || busy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_async: SOut=%b Busy=%b Ready=%b expected 1,0,0",
               sout[0], busy[0], rdy[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rdy[0] !== 1'b1 || busy[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_release: Ready=%b Busy=%b expected 1,0", rdy[0], busy[0]);
    end
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      tests_run++;
      if (sout[0] !== 1'b1 || busy[0] !== 1'b0) begin
        tests_failed++;
        $display("FAIL midframe_quiet cyc%0d: SOut=%b Busy=%b expected 1,0",
                 i, sout[0], busy[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_stop2();
    test_idle();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmitter: the send-side counterpart of the bench/host-side UART receiver that decodes DUT terminal output.
- Accepts Width-bit words on a ready/valid interface and buffers them in a small FIFO.
- Serializes each word onto SOut as an 8N1-style frame: start bit, data bits LSB-first, optional parity, stop bit(s).
- Used by test tops to print status over uart_txd, and by benches to drive a DUT's UART receive pin.

Parameters:
- ClockFreq, 200000000: Clock frequency in Hz.
- Baud, 9600: line rate in bits/s. Divisor = ClockFreq/Baud, integer truncation, must be >= 2.
- Width, 8: data bits per frame.
- Parity, 0: 0 = none, 1 = odd, 2 = even.
- StopBits, 1: number of stop bits, 1 or 2.
- FIFODepth, 4: buffered words, power of 2, >= 2.

Ports:
- Clock  in  1  sole clock.
- Reset  in  1  asynchronous, active-low reset.
- DataIn  in  Width  word to send.
- DataInValid  in  1  DataIn is valid.
- DataInReady  out  1  FIFO can accept a word this cycle.
- SOut  out  1  serial line; idles high.
- Busy  out  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (Reset=0, asynchronous):
  - SOut=1, DataInReady=0 while asserted, Busy=0.
  - FIFO empty, FSM in IDLE, all counters 0.
  - After release, DataInReady=1 on the first clock edge.
  - Reset mid-frame aborts the frame immediately, SOut=1, and discards FIFO contents.
- Handshake:
  - A word is accepted on an edge where DataInValid && DataInReady.
  - DataInReady = (count < FIFODepth). It is registered from the count and does not look ahead to a same-cycle pop.
  - While full, DataInReady=0 and DataIn is ignored.
  - A simultaneous push and pop leaves count unchanged and preserves order.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: SOut=1. If the FIFO is non-empty at an edge, pop the head into the shift register, SOut<=0, go to START.
  - Latency: a word accepted at edge k into an empty FIFO while IDLE gives a SOut falling edge at k+1.
  - Each state/bit holds SOut for exactly Divisor cycles using a baud counter that counts 0..Divisor-1 and restarts on every bit boundary.
  - START -> DATA: Width bits, LSB first, via a bit counter 0..Width-1 and a right shift.
  - DATA -> PARITY if Parity!=0, else -> STOP. The parity bit is the XOR of the data bits for even, inverted for odd.
  - STOP: SOut=1 for StopBits*Divisor cycles.
  - At the end of STOP: if the FIFO is non-empty, pop and drive the next start bit on the same edge (back-to-back, no idle gap); else go to IDLE.
- Frame length: (1 + Width + (Parity!=0) + StopBits) * Divisor cycles.
- Busy = (state != IDLE) || (count != 0).
- Arithmetic: the baud counter is clog2(Divisor) bits wide. The bit counter is clog2(Width+1) bits. The FIFO pointers wrap modulo FIFODepth, with count width clog2(FIFODepth+1).

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PARITY_NONE/ODD/EVEN,
  - the FSM state localparams,
  - a divisor function (ClockFreq, Baud).
- Sub-module uart_tx_fifo: synchronous FIFO with count/full/empty flags and the same async active-low Reset.
- The serializer FSM stays in the top module.

Test Plan:
- ClockFreq=1000, Baud=100 (Divisor=10), 8N1. Send 0x55 -> SOut: 0 for 10 cycles, then 1,0,1,0,1,0,1,0 each for 10 cycles, then 1 for 10 cycles; total 100 cycles. Busy falls at cycle 100.
- Same config, Parity=2. Send 0x07 -> parity bit = 1 after the data; frame is 110 cycles. With Parity=1 the parity bit = 0.
- Push 0x41, 0x42, 0x43, 0x44, 0x45 on consecutive cycles, FIFODepth=4 -> one word pops into the shift register, so all 5 are accepted before full. The 6th push sees DataInReady=0 until the first frame ends. Frames are back-to-back with no idle cycles, and the loopback receiver prints "ABCDE".
- Assert Reset low 35 cycles into a frame -> SOut=1 asynchronously, Busy=0, the FIFO is empty after release, and no further frames are sent.
- StopBits=2 -> SOut high for 20 cycles between consecutive frames. Holding DataInValid=0 keeps SOut=1 indefinitely.
